// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: single-outstanding req/ack fetch with stall/flush handling.
// Optional FETCH_PERF_EN adds stall and bubble cycle counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_br_target,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_d_pc,
    output logic [31:0] o_d_instr,
    output logic        o_d_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_BUF,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic        d_valid_q, d_valid_d;
    logic        load_bubble;

    // DROP keeps presenting the killed fetch's address while pc already holds the redirect.
    assign o_imem_req  = i_rst_n && (state_q == S_FETCH || state_q == S_DROP);
    assign o_imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign o_d_pc      = d_pc_q;
    assign o_d_instr   = d_instr_q;
    assign o_d_valid   = d_valid_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        d_pc_d      = d_pc_q;
        d_instr_d   = d_instr_q;
        d_valid_d   = d_valid_q;
        load_bubble = 1'b0;

        if (i_flush) begin
            load_bubble = 1'b1;
            pc_d        = i_br_target & ~32'h3;
            buf_pc_d    = '0;
            buf_instr_d = '0;
            if (i_imem_ack || state_q == S_BUF) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_DROP;
                if (state_q == S_FETCH) begin
                    drop_addr_d = pc_q;
                end
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (i_imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (i_stall) begin
                            buf_pc_d    = pc_q;
                            buf_instr_d = i_imem_rdata;
                            state_d     = S_BUF;
                        end else begin
                            d_pc_d    = pc_q;
                            d_instr_d = i_imem_rdata;
                            d_valid_d = 1'b1;
                        end
                    end else if (!i_stall) begin
                        load_bubble = 1'b1;
                    end
                end
                S_BUF: begin
                    if (!i_stall) begin
                        d_pc_d    = buf_pc_q;
                        d_instr_d = buf_instr_q;
                        d_valid_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (!i_stall) begin
                        load_bubble = 1'b1;
                    end
                    if (i_imem_ack) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end

        if (load_bubble) begin
            d_valid_d = 1'b0;
            d_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            d_pc_q      <= '0;
            d_instr_q   <= NOP_INSTR;
            d_valid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            d_pc_q      <= d_pc_d;
            d_instr_q   <= d_instr_d;
            d_valid_q   <= d_valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (i_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (load_bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt  = stall_cnt_q;
    assign o_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-DROP sequence, randomized run vs model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, ack;
    logic [31:0] tgt, rdata;
    logic        req;
    logic [31:0] addr, d_pc, d_instr;
    logic        d_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_br_target  (tgt),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_ack   (ack),
        .i_imem_rdata (rdata),
        .o_d_pc       (d_pc),
        .o_d_instr    (d_instr),
        .o_d_valid    (d_valid)
`ifdef FETCH_PERF_EN
        ,
        .o_stall_cnt  (stall_cnt),
        .o_bubble_cnt (bubble_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    typedef struct {
        logic        stall;
        logic        flush;
        logic        ack;
        logic [31:0] tgt;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] edpc;
        logic        edv;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a fetch queue of at most one parked instruction plus a stale-request flag.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic [31:0] m_pc, m_drop_addr, m_dpc, m_dinstr;
    logic        m_drop, m_dv;
    ent_t        m_park[$];
    logic [31:0] m_stall_cnt, m_bub_cnt;

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_drop      = 1'b0;
        m_drop_addr = '0;
        m_park.delete();
        m_dpc       = '0;
        m_dinstr    = NOP_INSTR;
        m_dv        = 1'b0;
        m_stall_cnt = '0;
        m_bub_cnt   = '0;
    endtask

    task automatic model_bubble();
        m_dv     = 1'b0;
        m_dinstr = NOP_INSTR;
        m_bub_cnt++;
    endtask

    task automatic model_step(input logic s, input logic f, input logic a, input logic [31:0] t);
        ent_t e;
        if (s) m_stall_cnt++;
        if (f) begin
            model_bubble();
            if (m_drop) begin
                m_drop = !a;
            end else if (m_park.size() != 0) begin
                m_drop = 1'b0;
            end else if (!a) begin
                m_drop      = 1'b1;
                m_drop_addr = m_pc;
            end
            m_park.delete();
            m_pc = {t[31:2], 2'b00};
        end else if (m_drop) begin
            if (!s) model_bubble();
            if (a) m_drop = 1'b0;
        end else if (m_park.size() != 0) begin
            if (!s) begin
                e = m_park.pop_front();
                m_dpc = e.pc; m_dinstr = e.instr; m_dv = 1'b1;
            end
        end else if (a) begin
            if (s) m_park.push_back({m_pc, mem_word(m_pc)});
            else begin
                m_dpc = m_pc; m_dinstr = mem_word(m_pc); m_dv = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            model_bubble();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req"},     {31'd0, req},     32'd0);
        check({tag, " d_valid"}, {31'd0, d_valid}, 32'd0);
        check({tag, " d_instr"}, d_instr,          NOP_INSTR);
        check({tag, " d_pc"},    d_pc,             32'd0);
`ifdef FETCH_PERF_EN
        check({tag, " stall_cnt"},  stall_cnt,  32'd0);
        check({tag, " bubble_cnt"}, bubble_cnt, 32'd0);
`endif
    endtask

    task automatic drive(input logic s, input logic f, input logic a, input logic [31:0] t);
        stall = s; flush = f; ack = a; tgt = t;
        rdata = mem_word(addr);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);

        // Vector table: expected outputs seen before the row's inputs are applied.
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h00,  32'h00,  0});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h04,  32'h00,  1});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h08,  32'h04,  1});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h0C,  32'h08,  1});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 32'h10,  32'h0C,  1});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 32'h10,  32'h0C,  0});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h10,  32'h0C,  0});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h14,  32'h10,  1});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h18,  32'h14,  1});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h1C,  32'h18,  1});
        tbl.push_back('{1, 0, 1, 32'h0,   1, 32'h20,  32'h1C,  1});
        tbl.push_back('{1, 0, 0, 32'h0,   0, 32'h24,  32'h1C,  1});
        tbl.push_back('{0, 0, 0, 32'h0,   0, 32'h24,  32'h1C,  1});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h24,  32'h20,  1});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h28,  32'h24,  1});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h2C,  32'h28,  1});
        tbl.push_back('{0, 1, 0, 32'h100, 1, 32'h30,  32'h2C,  1});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 32'h30,  32'h2C,  0});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h30,  32'h2C,  0});
        tbl.push_back('{0, 0, 1, 32'h0,   1, 32'h100, 32'h2C,  0});
        tbl.push_back('{1, 0, 1, 32'h0,   1, 32'h104, 32'h100, 1});
        tbl.push_back('{1, 1, 0, 32'h100, 0, 32'h108, 32'h100, 1});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 32'h100, 32'h100, 0});
        tbl.push_back('{0, 0, 0, 32'h0,   1, 32'h100, 32'h100, 0});

        repeat (2) @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        #1;

        foreach (tbl[i]) begin
            check($sformatf("row%0d req", i),     {31'd0, req},     {31'd0, tbl[i].ereq});
            if (tbl[i].ereq)
                check($sformatf("row%0d addr", i), addr, tbl[i].eaddr);
            check($sformatf("row%0d d_pc", i),    d_pc,             tbl[i].edpc);
            check($sformatf("row%0d d_valid", i), {31'd0, d_valid}, {31'd0, tbl[i].edv});
            check($sformatf("row%0d d_instr", i), d_instr,
                  tbl[i].edv ? mem_word(tbl[i].edpc) : NOP_INSTR);
            drive(tbl[i].stall, tbl[i].flush, tbl[i].ack, tbl[i].tgt);
            @(negedge clk);
            #1;
        end

        // Flush into DROP with an unaligned target, then async reset mid-DROP.
        drive(0, 1, 0, 32'h203);
        @(negedge clk);
        #1;
        check("drop req",     {31'd0, req},     32'd1);
        check("drop addr",    addr,             32'h100);
        check("drop d_valid", {31'd0, d_valid}, 32'd0);
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_drop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset req",  {31'd0, req}, 32'd1);
        check("post_reset addr", addr,         RESET_PC);

        // Randomized run against the model, starting from the fresh reset state.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        s, f, a;
            logic [31:0] t;
            check($sformatf("rnd%0d req", c), {31'd0, req},
                  {31'd0, (m_drop || m_park.size() == 0)});
            if (req)
                check($sformatf("rnd%0d addr", c), addr, m_drop ? m_drop_addr : m_pc);
            check($sformatf("rnd%0d d_pc", c),    d_pc,             m_dpc);
            check($sformatf("rnd%0d d_instr", c), d_instr,          m_dinstr);
            check($sformatf("rnd%0d d_valid", c), {31'd0, d_valid}, {31'd0, m_dv});
`ifdef FETCH_PERF_EN
            check($sformatf("rnd%0d stall_cnt", c),  stall_cnt,  m_stall_cnt);
            check($sformatf("rnd%0d bubble_cnt", c), bubble_cnt, m_bub_cnt);
`endif
            s = ($urandom_range(3) == 0);
            f = ($urandom_range(11) == 0);
            a = req && ($urandom_range(1) == 1);
            t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15))
                                         : ($urandom & 32'h0000_0FFF);
            drive(s, f, a, t);
            model_step(s, f, a, t);
            @(negedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
